// File: rtl/sram_1w1r_fifo_ctrl.sv
// FIFO controller for a 1-write/1-read OpenRAM macro. It streams pushes into the write port and
// prefetches into a 2-entry output buffer so that pops see one word per cycle.
module sram_1w1r_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int USED_W = ADDR_WIDTH + 1;
  localparam logic [USED_W-1:0]     USED_FULL = USED_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [USED_W-1:0]     sram_used;
  logic                  vld_p1;
  logic [1:0]            occ_p2;
  logic [DATA_WIDTH-1:0] obuf0_p2, obuf1_p2;
  logic                  push, pop, issue;
  logic [2:0]            pending;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = !rst && (sram_used != USED_FULL);
  assign push      = in_valid && in_ready;
  assign out_valid = (occ_p2 != 2'd0);
  assign out_data  = obuf0_p2;
  assign pop       = out_valid && out_ready;

  // Issue only while buffered plus in-flight words, net of this cycle's pop, leave a free slot.
  assign pending = {1'b0, occ_p2} + {2'b00, vld_p1};
  assign issue   = !rst && (sram_used != '0) && (pending < (3'd2 + {2'b00, pop}));

  assign sram_csb0  = !push;
  assign sram_addr0 = wptr;
  assign sram_din0  = push ? in_data : '0;
  assign sram_csb1  = !issue;
  assign sram_addr1 = rptr;

  assign count = {1'b0, sram_used}
               + {{(ADDR_WIDTH+1){1'b0}}, vld_p1}
               + {{ADDR_WIDTH{1'b0}}, occ_p2};

  // p0 -> p1: write/read command issue into the macro
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      sram_used <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (push)  wptr <= next_ptr(wptr);
      if (issue) rptr <= next_ptr(rptr);
      case ({push, issue})
        2'b10:   sram_used <= sram_used + 1'b1;
        2'b01:   sram_used <= sram_used - 1'b1;
        default: sram_used <= sram_used;
      endcase
      vld_p1 <= issue;
    end
  end

  // p1 -> p2: macro read data lands in the output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_p2   <= 2'd0;
      obuf0_p2 <= '0;
      obuf1_p2 <= '0;
    end else begin
      case ({pop, vld_p1})
        2'b01: begin
          if (occ_p2 == 2'd0) obuf0_p2 <= sram_dout1;
          else                obuf1_p2 <= sram_dout1;
          occ_p2 <= occ_p2 + 2'd1;
        end
        2'b10: begin
          obuf0_p2 <= obuf1_p2;
          occ_p2   <= occ_p2 - 2'd1;
        end
        2'b11: begin
          if (occ_p2 == 2'd2) begin
            obuf0_p2 <= obuf1_p2;
            obuf1_p2 <= sram_dout1;
          end else begin
            obuf0_p2 <= sram_dout1;
          end
        end
        default: occ_p2 <= occ_p2;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// Directed bench for sram_1w1r_fifo_ctrl with a behavioural 1w1r macro and a push/pop scoreboard.
module tb_sram_1w1r_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW+1:0] count;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;

  int n_chk = 0;
  int n_err = 0;

  sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Macro model: ports captured at posedge, write then read at the following negedge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          m_wr, m_rd;
  logic [AW-1:0] m_wa, m_ra;
  logic [DW-1:0] m_wd;
  initial sram_dout1 = '0;
  always @(posedge clk) begin
    m_wr <= !sram_csb0;
    m_wa <= sram_addr0;
    m_wd <= sram_din0;
    m_rd <= !sram_csb1;
    m_ra <= sram_addr1;
  end
  always @(negedge clk) begin
    if (m_wr) mem[m_wa] = m_wd;
    if (m_rd) sram_dout1 = mem[m_ra];
  end

  // Scoreboard: order, occupancy and port-collision monitor.
  logic [DW-1:0] sb_q[$];
  int            mcnt = 0;
  always @(posedge rst) begin
    sb_q.delete();
    mcnt = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("sb_count", 64'(count), 64'(mcnt));
      if (!sram_csb0 && !sram_csb1) chk("no_collide", 64'(sram_addr0 != sram_addr1), 64'd1);
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        mcnt++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        else                  chk("sb_data", 64'(out_data), 64'(sb_q.pop_front()));
        mcnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, expv, seq;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_csb0", 64'(sram_csb0), 64'd1);
    chk("rst_csb1", 64'(sram_csb1), 64'd1);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single word: push in cycle N, visible in N+3.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    #1;
    chk("single_csb0", 64'(sram_csb0), 64'd0);
    chk("single_din0", 64'(sram_din0), 64'hDEADBEEF);
    chk("single_addr0", 64'(sram_addr0), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("single_n1_count", 64'(count), 64'd1);
    chk("single_n1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("single_n2_count", 64'(count), 64'd1);
    chk("single_n2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("single_n3_valid", 64'(out_valid), 64'd1);
    chk("single_n3_data", 64'(out_data), 64'hDEADBEEF);
    tick();
    chk("single_after_count", 64'(count), 64'd0);
    chk("single_after_valid", 64'(out_valid), 64'd0);

    // Fill to capacity, then drain; three rounds walk the pointers through the wrap.
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      acc = 0;
      for (int v = 0; v < 41; v++) begin
        in_valid = 1'b1;
        in_data  = 32'(r * 256 + v);
        if (in_ready) acc++;
        tick();
      end
      in_valid = 1'b0;
      tick();
      chk("fill_accepted", 64'(acc), 64'd34);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      chk("fill_count", 64'(count), 64'd34);
      out_ready = 1'b1;
      expv = 0;
      for (int c = 0; c < 60; c++) begin
        if (out_valid) begin
          chk("fill_data", 64'(out_data), 64'(r * 256 + expv));
          expv++;
        end
        tick();
      end
      chk("drain_pops", 64'(expv), 64'd34);
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_count", 64'(count), 64'd0);
    end

    // Streaming at full rate.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = 32'(1000 + i);
      if (i >= 3) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data", 64'(out_data), 64'(1000 + i - 3));
        chk("stream_count", 64'(count), 64'd3);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("stream_end_count", 64'(count), 64'd0);

    // Random backpressure on both sides.
    seq = 0;
    for (int c = 0; c < 20000 && seq < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 32'h8000_0000 | 32'(seq);
      if (in_valid && in_ready) seq++;
      tick();
    end
    chk("bp_pushed", 64'(seq), 64'd2000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (80) tick();
    chk("bp_count", 64'(count), 64'd0);
    chk("bp_sb_left", 64'(sb_q.size()), 64'd0);

    // Reset mid-operation with a read in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h5000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_count_before", 64'(count), 64'd9);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_csb0", 64'(sram_csb0), 64'd1);
    chk("mid_rst_csb1", 64'(sram_csb1), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_count", 64'(count), 64'd0);
    chk("mid_rel_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_data = 32'h12345678; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_n1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("mid_n2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("mid_n3_valid", 64'(out_valid), 64'd1);
    chk("mid_n3_data", 64'(out_data), 64'h12345678);
    tick();
    chk("mid_after_count", 64'(count), 64'd0);
    chk("mid_after_valid", 64'(out_valid), 64'd0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
